// File: rtl/traffic_light_timed.sv
// Two-road intersection controller: timed main/side phases, demand-driven side service,
// latched pedestrian request with walk, all-red clearance and a night flash mode.
module traffic_light_timed #(
  parameter int CNT_W        = 8,
  parameter int T_MAIN_GREEN = 20,
  parameter int T_SIDE_GREEN = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int T_FLASH      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       side_car,
  input  logic       ped_btn,
  input  logic       flash_en,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR_MS = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR_SM = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_MG = CNT_W'(T_MAIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_SG = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_FL = CNT_W'(T_FLASH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             toggle_q, toggle_d;
  logic             ped_q, ped_d;
  logic             timer_zero;
  logic             entering;

  function automatic logic [CNT_W-1:0] load_value(input state_t s);
    case (s)
      S_MG:        return LD_MG;
      S_MY, S_SY:  return LD_Y;
      S_SG:        return LD_SG;
      S_FLASH:     return LD_FL;
      default:     return LD_AR;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MG:    if (flash_en || (timer_zero && (side_car || ped_q))) state_d = S_MY;
      S_MY:    if (timer_zero) state_d = S_AR_MS;
      S_AR_MS: if (timer_zero) state_d = flash_en ? S_FLASH : S_SG;
      S_SG:    if (timer_zero || flash_en) state_d = S_SY;
      S_SY:    if (timer_zero) state_d = S_AR_SM;
      S_AR_SM: if (timer_zero) state_d = flash_en ? S_FLASH : S_MG;
      S_FLASH: if (!flash_en) state_d = S_AR_SM;
      default: state_d = S_AR_SM;
    endcase
  end

  assign entering = (state_d != state_q);

  // Timer reloads on every state entry; in FLASH it also paces the lamp toggle.
  always_comb begin
    timer_d  = sat_dec(timer_q);
    toggle_d = toggle_q;
    if (entering) begin
      timer_d  = load_value(state_d);
      toggle_d = (state_d == S_FLASH);
    end else if (state_q == S_FLASH && timer_zero) begin
      timer_d  = LD_FL;
      toggle_d = ~toggle_q;
    end
  end

  // A press on the very edge that enters SG is kept for the next side cycle.
  assign ped_d = ped_btn | (ped_q & ~(entering && state_d == S_SG));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_AR_SM;
      timer_q  <= LD_AR;
      toggle_q <= 1'b0;
      ped_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      toggle_q <= toggle_d;
      ped_q    <= ped_d;
    end
  end

  always_comb begin
    main_red    = 1'b0;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b0;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    case (state_q)
      S_MG: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      S_MY: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      S_SG: begin
        main_red   = 1'b1;
        side_green = 1'b1;
        walk       = 1'b1;
      end
      S_SY: begin
        main_red    = 1'b1;
        side_yellow = 1'b1;
      end
      S_FLASH: begin
        main_yellow = toggle_q;
        side_red    = toggle_q;
      end
      default: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

  a_no_conflict: assert property (@(posedge clk) disable iff (!reset_n)
    !((main_green || main_yellow) && (side_green || side_yellow)));
  a_walk_only_sg: assert property (@(posedge clk) disable iff (!reset_n)
    walk |-> side_green);

endmodule

// File: tb/tb_traffic_light_timed.sv
// Bench for traffic_light_timed: constant vector table, reset corner case and a
// randomized run against an elapsed-time reference model.
module tb_traffic_light_timed;

  localparam int CNT_W = 8;
  localparam int TMG   = 20;
  localparam int TSG   = 10;
  localparam int TY    = 3;
  localparam int TAR   = 2;
  localparam int TFL   = 4;

  // {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
  localparam logic [6:0] L_MG  = 7'b0011000;
  localparam logic [6:0] L_MY  = 7'b0101000;
  localparam logic [6:0] L_AR  = 7'b1001000;
  localparam logic [6:0] L_SG  = 7'b1000011;
  localparam logic [6:0] L_SY  = 7'b1000100;
  localparam logic [6:0] L_FL1 = 7'b0101000;
  localparam logic [6:0] L_OFF = 7'b0000000;

  logic clk = 1'b0;
  logic reset_n, side_car, ped_btn, flash_en;
  logic main_red, main_yellow, main_green, side_red, side_yellow, side_green;
  logic walk, ped_pending;
  logic [2:0] phase;
  logic [6:0] lamps;

  int checks = 0;
  int errors = 0;

  int m_phase;
  int m_el;
  bit m_pend;

  typedef struct {
    int         n;
    logic       sc;
    logic       pb;
    logic       fl;
    logic [2:0] ph;
    logic [6:0] lm;
    logic       pd;
  } vec_t;
  vec_t vq[$];

  traffic_light_timed #(
    .CNT_W(CNT_W), .T_MAIN_GREEN(TMG), .T_SIDE_GREEN(TSG),
    .T_YELLOW(TY), .T_ALL_RED(TAR), .T_FLASH(TFL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .side_car(side_car), .ped_btn(ped_btn),
    .flash_en(flash_en), .main_red(main_red), .main_yellow(main_yellow),
    .main_green(main_green), .side_red(side_red), .side_yellow(side_yellow),
    .side_green(side_green), .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lamps follow directly from the phase and how long it has been active.
  function automatic logic [6:0] model_lamps(input int ph, input int el);
    case (ph)
      0: return L_MG;
      1: return L_MY;
      3: return L_SG;
      4: return L_SY;
      6: return (((el / TFL) % 2) == 0) ? L_FL1 : L_OFF;
      default: return L_AR;
    endcase
  endfunction

  task automatic reset_model();
    m_phase = 5;
    m_el    = 0;
    m_pend  = 1'b0;
  endtask

  task automatic model_step();
    int nx;
    nx = m_phase;
    case (m_phase)
      0: if (flash_en || (m_el >= TMG - 1 && (side_car || m_pend))) nx = 1;
      1: if (m_el >= TY - 1) nx = 2;
      2: if (m_el >= TAR - 1) nx = flash_en ? 6 : 3;
      3: if (m_el >= TSG - 1 || flash_en) nx = 4;
      4: if (m_el >= TY - 1) nx = 5;
      5: if (m_el >= TAR - 1) nx = flash_en ? 6 : 0;
      default: if (!flash_en) nx = 5;
    endcase
    m_pend = ped_btn | (m_pend & !(nx == 3 && m_phase != 3));
    if (nx != m_phase) m_el = 0;
    else m_el++;
    m_phase = nx;
  endtask

  task automatic check_model();
    check("model", {5'd0, phase, lamps, ped_pending},
          {5'd0, 3'(m_phase), model_lamps(m_phase, m_el), m_pend});
    check("safety", 16'((main_green | main_yellow) & (side_green | side_yellow)), 16'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic add_vec(input int n, input logic sc, input logic pb, input logic fl,
                         input logic [2:0] ph, input logic [6:0] lm, input logic pd);
    vec_t v;
    v.n = n; v.sc = sc; v.pb = pb; v.fl = fl; v.ph = ph; v.lm = lm; v.pd = pd;
    vq.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; side_car = 1'b0; ped_btn = 1'b0; flash_en = 1'b0;
    reset_model();

    //     n   sc    pb    fl   ph    lamps  pend
    add_vec(0,   0, 0, 0, 3'd5, L_AR,  0);
    add_vec(1,   0, 0, 0, 3'd5, L_AR,  0);
    add_vec(1,   0, 0, 0, 3'd0, L_MG,  0);
    add_vec(5,   0, 0, 0, 3'd0, L_MG,  0);
    add_vec(14,  1, 0, 0, 3'd0, L_MG,  0);
    add_vec(1,   1, 0, 0, 3'd1, L_MY,  0);
    add_vec(2,   1, 0, 0, 3'd1, L_MY,  0);
    add_vec(1,   1, 0, 0, 3'd2, L_AR,  0);
    add_vec(1,   1, 0, 0, 3'd2, L_AR,  0);
    add_vec(1,   1, 0, 0, 3'd3, L_SG,  0);
    add_vec(9,   1, 0, 0, 3'd3, L_SG,  0);
    add_vec(1,   1, 0, 0, 3'd4, L_SY,  0);
    add_vec(3,   1, 0, 0, 3'd5, L_AR,  0);
    add_vec(2,   1, 0, 0, 3'd0, L_MG,  0);
    add_vec(100, 0, 0, 0, 3'd0, L_MG,  0);
    add_vec(1,   0, 1, 0, 3'd0, L_MG,  1);
    add_vec(1,   0, 0, 0, 3'd1, L_MY,  1);
    add_vec(5,   0, 0, 0, 3'd3, L_SG,  0);
    add_vec(1,   0, 1, 0, 3'd3, L_SG,  1);
    add_vec(9,   0, 0, 0, 3'd4, L_SY,  1);
    add_vec(5,   0, 0, 0, 3'd0, L_MG,  1);
    add_vec(19,  0, 0, 0, 3'd0, L_MG,  1);
    add_vec(1,   0, 0, 0, 3'd1, L_MY,  1);
    add_vec(5,   0, 0, 0, 3'd3, L_SG,  0);
    add_vec(1,   0, 0, 1, 3'd4, L_SY,  0);
    add_vec(3,   0, 0, 1, 3'd5, L_AR,  0);
    add_vec(2,   0, 0, 1, 3'd6, L_FL1, 0);
    add_vec(3,   0, 0, 1, 3'd6, L_FL1, 0);
    add_vec(1,   0, 0, 1, 3'd6, L_OFF, 0);
    add_vec(4,   0, 0, 1, 3'd6, L_FL1, 0);
    add_vec(1,   0, 0, 0, 3'd5, L_AR,  0);
    add_vec(2,   0, 0, 0, 3'd0, L_MG,  0);
    add_vec(3,   0, 0, 0, 3'd0, L_MG,  0);
    add_vec(1,   0, 0, 1, 3'd1, L_MY,  0);
    add_vec(3,   0, 0, 1, 3'd2, L_AR,  0);
    add_vec(2,   0, 0, 1, 3'd6, L_FL1, 0);
    add_vec(1,   0, 0, 0, 3'd5, L_AR,  0);
    add_vec(2,   0, 0, 0, 3'd0, L_MG,  0);
    add_vec(20,  1, 0, 0, 3'd1, L_MY,  0);
    add_vec(15,  0, 0, 0, 3'd4, L_SY,  0);
    add_vec(1,   0, 0, 1, 3'd4, L_SY,  0);
    add_vec(2,   0, 0, 1, 3'd5, L_AR,  0);
    add_vec(1,   0, 0, 1, 3'd5, L_AR,  0);
    add_vec(1,   0, 0, 1, 3'd6, L_FL1, 0);
    add_vec(1,   0, 0, 0, 3'd5, L_AR,  0);
    add_vec(2,   0, 0, 0, 3'd0, L_MG,  0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {5'd0, phase, lamps, ped_pending}, {5'd0, 3'd5, L_AR, 1'b0});
    reset_n = 1'b1;

    foreach (vq[i]) begin
      side_car = vq[i].sc;
      ped_btn  = vq[i].pb;
      flash_en = vq[i].fl;
      for (int k = 0; k < vq[i].n; k++) step();
      check($sformatf("vec%0d_phase", i), 16'(phase), 16'(vq[i].ph));
      check($sformatf("vec%0d_lamps", i), 16'(lamps), 16'(vq[i].lm));
      check($sformatf("vec%0d_pend", i), 16'(ped_pending), 16'(vq[i].pd));
    end

    // Reset asserted part-way through side green must go all-red at once.
    side_car = 1'b1; ped_btn = 1'b0; flash_en = 1'b0;
    repeat (25) step();
    side_car = 1'b0;
    repeat (3) step();
    check("pre_reset_sg", 16'(phase), 16'd3);
    reset_n = 1'b0;
    reset_model();
    #1;
    check("reset_mid_sg", {5'd0, phase, lamps, ped_pending}, {5'd0, 3'd5, L_AR, 1'b0});
    @(posedge clk);
    #1;
    check("reset_held", {5'd0, phase, lamps, ped_pending}, {5'd0, 3'd5, L_AR, 1'b0});
    reset_n = 1'b1;
    repeat (3) step();
    check("after_reset_mg", 16'(phase), 16'd0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) side_car = ~side_car;
      ped_btn = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) flash_en = ~flash_en;
      if ($urandom_range(0, 799) == 0) begin
        reset_n = 1'b0;
        reset_model();
        #1;
        check_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
